// File: rtl/vga_param_ctrl.sv
// vga_param_ctrl: parameterised VGA timing generator with registered DAC outputs.
// Define VGA_PATTERN_EN to add swap-button selectable test patterns (bars, checkerboard, white).
module vga_param_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 swap,
    input  logic [3*COLOR_W-1:0] pixel_in,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 vga_sync_n,
    output logic                 vga_blank_n,
    output logic                 vga_clk,
    output logic [10:0]          h_count,
    output logic [10:0]          v_count,
    output logic                 frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOT - 1);

    logic [DW-1:0]        div_q, div_d;
    logic [10:0]          h_q, h_d, v_q, v_d;
    logic                 hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d, colour;
    logic                 pix_en, active;

    always_comb begin
        pix_en      = div_q == DW'(CLK_DIV - 1);
        div_d       = pix_en ? '0 : div_q + 1'b1;
        h_d         = pix_en ? ((h_q == H_LAST) ? '0 : h_q + 11'd1) : h_q;
        v_d         = (pix_en && h_q == H_LAST) ? ((v_q == V_LAST) ? '0 : v_q + 11'd1) : v_q;
        frame_start = pix_en && h_q == '0 && v_q == '0;
        active      = h_q < H_ACT && v_q < V_ACT;
        hs_d        = pix_en ? !(h_q >= H_SYNC_LO && h_q < H_SYNC_HI) : hs_q;
        vs_d        = pix_en ? !(v_q >= V_SYNC_LO && v_q < V_SYNC_HI) : vs_q;
        blank_d     = pix_en ? active : blank_q;
        rgb_d       = pix_en ? (active ? colour : '0) : rgb_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

`ifdef VGA_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
    // Bar colours as {R,G,B} flags, index 0 (white) is the leftmost bar
    localparam logic [7:0][2:0] BAR_LUT = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
    logic       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, pending_q, pending_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] pat;

    always_comb begin
        sync1_d   = swap;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        pending_d = (sync3_q && !sync2_q) ? 1'b1 : (frame_start ? 1'b0 : pending_q);
        mode_d    = (frame_start && pending_q) ? mode_q + 2'd1 : mode_q;
        pat       = (mode_q == 2'd1) ? BAR_LUT[3'(h_q / BAR_W)] :
                    (mode_q == 2'd2) ? {3{h_q[5] ^ v_q[5]}} : 3'b111;
        colour    = (mode_q == 2'd0) ? pixel_in :
                    {{COLOR_W{pat[2]}}, {COLOR_W{pat[1]}}, {COLOR_W{pat[0]}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            pending_q <= 1'b0;
            mode_q    <= 2'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
        end
    end
`else
    logic unused_swap;
    assign unused_swap = swap;
    assign colour      = pixel_in;
`endif

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = div_q >= DW'(CLK_DIV / 2);
    assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue        = rgb_q[COLOR_W-1:0];
    assign h_count     = h_q;
    assign v_count     = v_q;
endmodule

// File: tb/tb_vga_param_ctrl.sv
// tb_vga_param_ctrl: reduced-size timing run checked cycle by cycle against a pixel-index model.
module tb_vga_param_ctrl;
    localparam int HA = 64, HF = 4, HS = 6, HB = 6;
    localparam int VA = 40, VF = 2, VS = 3, VB = 3;
    localparam int CD = 3, CW = 8;
    localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, F = HT * VT;
`ifdef VGA_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic clk = 1'b0, reset, swap;
    logic [3*CW-1:0] pixel_in;
    logic vga_hs, vga_vs, vga_sync_n, vga_blank_n, vga_clk, frame_start;
    logic [CW-1:0] red, green, blue;
    logic [10:0] h_count, v_count;

    vga_param_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .COLOR_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .swap(swap), .pixel_in(pixel_in),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .red(red), .green(green), .blue(blue),
        .vga_sync_n(vga_sync_n), .vga_blank_n(vga_blank_n), .vga_clk(vga_clk),
        .h_count(h_count), .v_count(v_count), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n, errs, checks, cyc, hs_low, vs_low;
    bit in_rst, rand_px, seen_fs;
    logic e_hs, e_vs, e_blank;
    logic [3*CW-1:0] e_rgb;
    int press_frames[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // A press during frame f takes effect for pixels after the first pixel of frame f+1
    function automatic int mode_of(int k);
        int m = 0;
        if (PAT) foreach (press_frames[i]) if ((press_frames[i] + 1) * F < k) m++;
        return m % 4;
    endfunction

    function automatic logic [3*CW-1:0] colour(int h, int v, int m, logic [3*CW-1:0] pin);
        logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        logic [2:0] c;
        if (h >= HA || v >= VA) return '0;
        if (m == 0) return pin;
        c = (m == 1) ? bars[h / (HA / 8)] : (m == 2) ? {3{((h / 32 + v / 32) % 2) == 1}} : 3'b111;
        return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
    endfunction

    task automatic tick();
        int k, h, v, k2;
        logic [51:0] exp;
        if (!in_rst && n % CD == CD - 1) begin
            k = n / CD; h = k % HT; v = (k / HT) % VT;
            e_hs    = !(h >= HA + HF && h < HA + HF + HS);
            e_vs    = !(v >= VA + VF && v < VA + VF + VS);
            e_blank = h < HA && v < VA;
            e_rgb   = colour(h, v, mode_of(k), pixel_in);
        end
        @(posedge clk);
        if (!in_rst) n++;
        @(negedge clk);
        k2  = n / CD;
        exp = {e_hs, e_vs, e_blank, 1'b0, (n % CD) >= CD / 2,
               (n % CD == CD - 1) && (k2 % F == 0), 11'(k2 % HT), 11'((k2 / HT) % VT), e_rgb};
        checks++;
        assert ({vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start,
                 h_count, v_count, red, green, blue} === exp) else begin
            errs++;
            $error("FAIL cycle n=%0d: observed %0h expected %0h", n,
                   {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start,
                    h_count, v_count, red, green, blue}, exp);
        end
        cyc++;
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (frame_start) begin
            if (seen_fs) begin
                chk("fs_period", cyc, F * CD);
                chk("hs_low_per_frame", hs_low, VT * HS * CD);
                chk("vs_low_per_frame", vs_low, VS * HT * CD);
            end
            seen_fs = 1'b1; cyc = 0; hs_low = 0; vs_low = 0;
        end
        if (rand_px) pixel_in = $urandom;
    endtask

    task automatic run_to(int k);
        int lim = 0;
        while (!(n % CD == 0 && n / CD == k) && lim < 30000) begin
            tick();
            lim++;
        end
        if (lim >= 30000) begin
            checks++; errs++;
            $error("FAIL run_to timeout: observed pixel %0d expected %0d", n / CD, k);
        end
    endtask

    task automatic press();
        int f = (n / CD) / F;
        if (press_frames.size() == 0 || press_frames[$] != f) press_frames.push_back(f);
        swap = 1'b0;
        repeat (4) tick();
        swap = 1'b1;
        repeat (4) tick();
    endtask

    task automatic rst_checks(input string p);
        chk({p, "_hs"}, vga_hs, 1);
        chk({p, "_vs"}, vga_vs, 1);
        chk({p, "_blank"}, vga_blank_n, 0);
        chk({p, "_sync"}, vga_sync_n, 0);
        chk({p, "_rgb"}, {red, green, blue}, 0);
        chk({p, "_fs"}, frame_start, 0);
        chk({p, "_vclk"}, vga_clk, 0);
        chk({p, "_hv"}, {h_count, v_count}, 0);
    endtask

    task automatic enter_reset();
        reset = 1'b0; in_rst = 1'b1; swap = 1'b1;
        n = 0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = '0;
        press_frames.delete();
        seen_fs = 1'b0; cyc = 0; hs_low = 0; vs_low = 0;
    endtask

    task automatic release_and_check();
        #1 reset = 1'b1; in_rst = 1'b0;
        tick();
        chk("fs_before_first_pix", frame_start, 0);
        tick();
        chk("fs_first_pix", frame_start, 1);
    endtask

    initial begin
        errs = 0; checks = 0; rand_px = 1'b1; pixel_in = '0;
        enter_reset();
        repeat (2) @(negedge clk);
        rst_checks("rst");
        repeat (3) tick();
        release_and_check();
        run_to(3 * HT);
        rand_px = 1'b0;
        pixel_in = 24'h123456;
        run_to(3 * HT + 11);
        chk("active_rgb", {red, green, blue}, 24'h123456);
        chk("active_blank", vga_blank_n, 1);
        run_to(3 * HT + 70);
        chk("porch_rgb", {red, green, blue}, 0);
        chk("porch_blank", vga_blank_n, 0);
        chk("hsync_low", vga_hs, 0);
        rand_px = 1'b1;
        run_to(43 * HT + 1);
        chk("vsync_low", vga_vs, 0);
        run_to(45 * HT + 1);
        chk("vsync_high", vga_vs, 1);
        run_to(F + 500);
        repeat (3) begin
            press();
            repeat (3) tick();
        end
        run_to(2 * F + 11);
`ifdef VGA_PATTERN_EN
        chk("bar1_yellow", {red, green, blue}, 24'hFFFF00);
`endif
        run_to(2 * F + 500);
        press();
        run_to(3 * F + 500);
        press();
        run_to(4 * F + 2 * HT + 70);
        @(negedge clk);
        #2 enter_reset();
        #1 rst_checks("midrst");
        repeat (4) tick();
        release_and_check();
        run_to(2 * HT + 5);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/vga_param_ctrl.md
VGA_PARAM_CTRL -- requirements
Module: vga_param_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter CLK_DIV, default 2, clk cycles per pixel, legal values 2 or more.
REQ-010 The block SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-011 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-012 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-013 The block SHALL have port swap, input, 1 bit, active-low pattern-mode button, asynchronous to clk.
REQ-014 The block SHALL have port pixel_in, input, 3*COLOR_W bits, external colour {R,G,B} for the requested coordinate.
REQ-015 The block SHALL have ports vga_hs and vga_vs, outputs, 1 bit each, active-low sync pulses.
REQ-016 The block SHALL have ports red, green and blue, outputs, COLOR_W bits each, DAC colour.
REQ-017 The block SHALL have ports vga_sync_n and vga_blank_n, outputs, 1 bit each, DAC sync and blank controls.
REQ-018 The block SHALL have port vga_clk, output, 1 bit, DAC pixel clock.
REQ-019 The block SHALL have ports h_count and v_count, outputs, 11 bits each, requested pixel coordinate.
REQ-020 The block SHALL have port frame_start, output, 1 bit, one-clk pulse at the start of each frame.

Function
REQ-021 A divider SHALL count 0..CLK_DIV-1 and assert internal pix_en in the clk cycle where the count equals CLK_DIV-1.
REQ-022 vga_clk SHALL be low while the divider count is below CLK_DIV/2 and high otherwise, giving a mid-pixel rising edge.
REQ-023 On each pix_en, h_count SHALL increment and wrap from H_TOT-1 to 0, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-024 On the h_count wrap, v_count SHALL increment and wrap from V_TOT-1 to 0, where V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-025 frame_start SHALL be high for exactly one clk, in the pix_en cycle where h_count and v_count are both 0.
REQ-026 All video outputs SHALL be registered on pix_en from the current (pre-increment) counters and pixel_in, giving one pixel period of latency.
REQ-027 vga_hs SHALL be 0 iff h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vga_vs SHALL follow the same rule on v with the V_* parameters.
REQ-028 vga_blank_n SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE; vga_sync_n SHALL be held at 0.
REQ-029 Outside the active region, red, green and blue SHALL be all zeros regardless of mode.
REQ-030 Mode 0 SHALL output pixel_in, split as red = MSB field and blue = LSB field.
REQ-031 swap SHALL pass through a 2-flop synchronizer; a synchronized 1-to-0 transition SHALL set a pending flag.
REQ-032 A pending press SHALL advance the mode (0 to 3, wrapping to 0) at the next frame_start and then clear; multiple presses within one frame SHALL count as one.

Reset
REQ-033 While reset is 0, the divider, counters, mode and pending flag SHALL clear to 0, and vga_clk, frame_start, vga_sync_n and red/green/blue SHALL be 0.
REQ-034 While reset is 0, vga_hs, vga_vs and the synchronizer flops SHALL be 1 and vga_blank_n SHALL be 0; after release, the first pix_en SHALL occur CLK_DIV clk cycles later.

Configuration
REQ-035 With VGA_PATTERN_EN defined: mode 1 SHALL give 8 vertical bars of H_ACTIVE/8 pixels (white, yellow, cyan, green, magenta, red, blue, black), mode 2 a 32x32 checkerboard (white iff h[5]^v[5]), and mode 3 solid white.
REQ-036 Without VGA_PATTERN_EN: swap SHALL be ignored, mode SHALL stay 0, and pattern logic SHALL be absent.

Verification
REQ-037 Defaults, run 2 frames -> 800 pixels/line (1600 clk), 525 lines/frame, frame_start period 840000 clk.
REQ-038 Defaults -> vga_hs low 192 clk starting 656 pixels after line start; vga_vs low for 1600 pixels starting at line 490.
REQ-039 Mode 0 with pixel_in=0x123456 -> active pixels read R=0x12, G=0x34, B=0x56; porch pixels read 0 with vga_blank_n=0.
REQ-040 (VGA_PATTERN_EN) 3 swap presses in one frame -> mode goes 0->1 only, at the next frame_start; pixel 80 of the next frame is yellow.
REQ-041 reset asserted mid-line -> outputs reach their REQ-033/034 values immediately; after release, counters restart at 0,0 and frame_start pulses at the first pix_en.
